// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, instruction geometry and the
// opcode length table used by both fetch and decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StDrain
  } fetch_state_e;

  localparam int unsigned InstrByteW     = 8;
  localparam int unsigned InstrMaxLen    = 3;
  localparam int unsigned OpcLenMsb      = 7;
  localparam int unsigned OpcLenLsb      = 6;
  localparam int unsigned ResetVectorDef = 0;

  // Two bits per entry, indexed by opcode[7:6]: 00->1, 01->2, 10->3, 11->1.
  localparam logic [7:0] LenTable = {2'd1, 2'd3, 2'd2, 2'd1};

  function automatic logic [1:0] instr_len_of(input logic [InstrByteW-1:0] opcode);
    logic [1:0] field;
    field = opcode[OpcLenMsb:OpcLenLsb];
    return LenTable[{field, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational instruction length decode from the first instruction byte.
module ifetch_len_decode
  import cpu_pkg::*;
(
  input  logic [InstrByteW-1:0] opcode,
  output logic [1:0]            len
);

  always_comb begin
    len = instr_len_of(opcode);
  end

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: owns the PC, reads bytes over a req/ack handshake and
// hands complete 1-3 byte instructions to the decoder over valid/ready.
module cpu_ifetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned RESET_VECTOR = ResetVectorDef
) (
  input  logic                              clk,
  input  logic                              reset_,
  input  logic                              ifetch_en,
  input  logic                              pc_reset,
  input  logic                              pc_branch,
  input  logic [ADDR_W-1:0]                 branch_target,
  output logic                              mem_rd_req,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic                              mem_rd_ack,
  input  logic [InstrByteW-1:0]             mem_rd_data,
  output logic                              instr_valid,
  input  logic                              instr_ready,
  output logic [InstrMaxLen*InstrByteW-1:0] instr_data,
  output logic [1:0]                        instr_len,
  output logic [ADDR_W-1:0]                 instr_pc
);

  localparam logic [ADDR_W-1:0] RstVec = ADDR_W'(RESET_VECTOR);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [1:0] count_q, count_d;
  logic [1:0] len_q, len_d;
  logic [InstrMaxLen*InstrByteW-1:0] data_q, data_d;

  logic [1:0] byte0_len, cur_len;
  logic req, ack, flush, last_byte;
  logic [ADDR_W-1:0] flush_pc;

  ifetch_len_decode u_len_decode (
    .opcode(mem_rd_data),
    .len   (byte0_len)
  );

  always_comb begin
    req       = (state_q == StFetch && ifetch_en) || state_q == StWait || state_q == StDrain;
    ack       = req & mem_rd_ack;
    flush     = pc_reset | pc_branch;
    flush_pc  = pc_reset ? RstVec : branch_target;
    cur_len   = (count_q == 2'd0) ? byte0_len : len_q;
    last_byte = (count_q + 2'd1) == cur_len;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_pc_d   = instr_pc_q;
    count_d      = count_q;
    len_d        = len_q;
    data_d       = data_q;

    unique case (state_q)
      StFetch, StWait: begin
        if (flush) begin
          pc_d    = flush_pc;
          count_d = 2'd0;
          // A raised request cannot be withdrawn; remember its address and swallow the data.
          if (req && !ack) begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end else begin
            state_d = StFetch;
          end
        end else if (ack) begin
          pc_d = pc_q + ADDR_W'(1);
          case (count_q)
            2'd0: begin
              data_d     = {{(2*InstrByteW){1'b0}}, mem_rd_data};
              len_d      = byte0_len;
              instr_pc_d = pc_q;
            end
            2'd1:    data_d[2*InstrByteW-1:InstrByteW]   = mem_rd_data;
            default: data_d[3*InstrByteW-1:2*InstrByteW] = mem_rd_data;
          endcase
          if (last_byte) begin
            state_d = StHold;
            count_d = 2'd0;
          end else begin
            state_d = StFetch;
            count_d = count_q + 2'd1;
          end
        end else if (req) begin
          state_d = StWait;
        end
      end
      StHold: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = StFetch;
        end else if (instr_ready) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (flush) begin
          pc_d = flush_pc;
        end
        if (ack) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q      <= StFetch;
      pc_q         <= RstVec;
      drain_addr_q <= RstVec;
      instr_pc_q   <= RstVec;
      count_q      <= 2'd0;
      len_q        <= 2'd1;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_pc_q   <= instr_pc_d;
      count_q      <= count_d;
      len_q        <= len_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    mem_rd_req  = req;
    mem_addr    = (state_q == StDrain) ? drain_addr_q : pc_q;
    instr_valid = (state_q == StHold);
    instr_data  = data_q;
    instr_len   = len_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch: byte-wide memory model with programmable ack latency and
// a scoreboard of expected instructions compared at each decoder consume.
module tb_cpu_ifetch;

  logic        clk = 1'b0;
  logic        reset_;
  logic        ifetch_en;
  logic        pc_reset;
  logic        pc_branch;
  logic [7:0]  branch_target;
  logic        mem_rd_req;
  logic [7:0]  mem_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr_data;
  logic [1:0]  instr_len;
  logic [7:0]  instr_pc;

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  len;
    logic [7:0]  pc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [256];
  int         ack_delay = 0;
  int         wait_cnt  = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  always #5 clk = ~clk;

  cpu_ifetch #(
    .ADDR_W      (8),
    .RESET_VECTOR(0)
  ) dut (
    .clk          (clk),
    .reset_       (reset_),
    .ifetch_en    (ifetch_en),
    .pc_reset     (pc_reset),
    .pc_branch    (pc_branch),
    .branch_target(branch_target),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc)
  );

  // Memory acks a request once it has been pending ack_delay cycles (0 = same cycle).
  always @(posedge clk) wait_cnt <= (mem_rd_req && !mem_rd_ack) ? wait_cnt + 1 : 0;
  assign mem_rd_ack  = mem_rd_req && (wait_cnt >= ack_delay);
  assign mem_rd_data = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic exp_req, input logic [7:0] exp_addr);
    chk({tag, "_req"}, mem_rd_req, exp_req);
    if (exp_req) chk({tag, "_addr"}, mem_addr, exp_addr);
  endtask

  task automatic push_exp(input logic [23:0] d, input logic [1:0] l, input logic [7:0] p);
    exp_t e;
    e.data = d;
    e.len  = l;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consume must match the oldest expected instruction.
  always @(negedge clk) begin
    if (reset_ === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      exp_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      chk("sb_data", instr_data, e.data);
      chk("sb_len", instr_len, e.len);
      chk("sb_pc", instr_pc, e.pc);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h40;
    mem[8'h01] = 8'h12;
    mem[8'h02] = 8'h05;
    mem[8'h03] = 8'h41;
    mem[8'h04] = 8'h99;
    mem[8'h05] = 8'hAA;
    mem[8'h10] = 8'h02;
    mem[8'h80] = 8'h3C;
    mem[8'h81] = 8'h01;
    mem[8'hFF] = 8'h80;

    reset_ = 1'b0; ifetch_en = 1'b0; pc_reset = 1'b0; pc_branch = 1'b0;
    branch_target = 8'h00; instr_ready = 1'b0;
    tick();
    tick();
    chk("rst_req", mem_rd_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 24'h0);
    chk("rst_len", instr_len, 2'd1);
    chk("rst_pc", instr_pc, 8'h00);

    // Zero-wait 2-byte fetch, then held for 5 cycles before consume.
    reset_ = 1'b1; ifetch_en = 1'b1;
    push_exp(24'h001240, 2'd2, 8'h00);
    #1 chk_req("t1_b0", 1'b1, 8'h00);
    tick(); chk_req("t1_b1", 1'b1, 8'h01);
    tick();
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_data", instr_data, 24'h001240);
    chk("t1_len", instr_len, 2'd2);
    chk("t1_ipc", instr_pc, 8'h00);
    chk_req("t1_hold", 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_stall_valid", instr_valid, 1'b1);
      chk("t3_stall_data", instr_data, 24'h001240);
      chk_req("t3_stall", 1'b0, 8'h00);
    end
    tick();
    instr_ready = 1'b1; ack_delay = 3;

    // Consume, then a slow read with ifetch_en dropped while it is pending.
    tick();
    chk("t3_after_consume_valid", instr_valid, 1'b0);
    chk_req("t3_next", 1'b1, 8'h02);
    push_exp(24'h000005, 2'd1, 8'h02);
    tick(); ifetch_en = 1'b0;
    #1 chk_req("t2_wait1", 1'b1, 8'h02);
    tick(); chk_req("t2_wait2", 1'b1, 8'h02);
    tick(); chk_req("t2_ackcyc", 1'b1, 8'h02);
    tick(); chk("t2_valid", instr_valid, 1'b1);
    tick(); chk_req("t2_idle0", 1'b0, 8'h00);
    chk("t2_idle_valid", instr_valid, 1'b0);
    tick(); chk_req("t2_idle1", 1'b0, 8'h00);
    ack_delay = 0; ifetch_en = 1'b1;
    push_exp(24'h009941, 2'd2, 8'h03);
    #1 chk_req("t2_resume", 1'b1, 8'h03);
    tick(); chk_req("t4_b1", 1'b1, 8'h04);
    tick(); chk("t4_valid", instr_valid, 1'b1);
    ack_delay = 2;

    // Branch while the read of 0x05 is outstanding; its data must be dropped.
    tick(); chk_req("t4_req5", 1'b1, 8'h05);
    pc_branch = 1'b1; branch_target = 8'h80;
    tick(); pc_branch = 1'b0;
    #1 chk_req("t4_drain0", 1'b1, 8'h05);
    chk("t4_drain_valid", instr_valid, 1'b0);
    tick(); chk_req("t4_drain_ack", 1'b1, 8'h05);
    ack_delay = 0;
    push_exp(24'h00003C, 2'd1, 8'h80);
    tick(); chk_req("t4_target", 1'b1, 8'h80);
    tick(); chk("t4_tgt_valid", instr_valid, 1'b1);

    // Branch in the same cycle as an ack.
    tick(); chk_req("t5_req81", 1'b1, 8'h81);
    pc_branch = 1'b1; branch_target = 8'h10;
    tick(); pc_branch = 1'b0;
    #1 chk_req("t5_target", 1'b1, 8'h10);
    chk("t5_valid", instr_valid, 1'b0);
    push_exp(24'h000002, 2'd1, 8'h10);

    // Consume and branch together, then a 3-byte fetch wrapping the PC.
    tick(); chk("t6_q_valid", instr_valid, 1'b1);
    pc_branch = 1'b1; branch_target = 8'hFF;
    push_exp(24'h124080, 2'd3, 8'hFF);
    tick(); pc_branch = 1'b0;
    #1 chk_req("t6_reqFF", 1'b1, 8'hFF);
    tick(); chk_req("t6_req00", 1'b1, 8'h00);
    tick(); chk_req("t6_req01", 1'b1, 8'h01);
    instr_ready = 1'b0;
    tick();
    chk("t6_valid", instr_valid, 1'b1);
    chk("t6_data", instr_data, 24'h124080);
    chk("t6_len", instr_len, 2'd3);
    chk("t6_ipc", instr_pc, 8'hFF);
    instr_ready = 1'b1;
    tick(); chk_req("t6_wrapped_pc", 1'b1, 8'h02);
    instr_ready = 1'b0;

    // Soft reset while an instruction is held.
    tick();
    chk("t7_valid", instr_valid, 1'b1);
    chk("t7_ipc", instr_pc, 8'h02);
    pc_reset = 1'b1;
    tick(); pc_reset = 1'b0;
    #1 chk("t7_flushed", instr_valid, 1'b0);
    chk_req("t7_rv", 1'b1, 8'h00);
    ifetch_en = 1'b0;
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
